// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving PRAM, register, ALU and SRAM strobes.
// Retires 3 cycles after fetch handshake (ALU 4, SRAM load 4+SRAM_RD_LAT); fetch stalls until instr_valid.
module instr_sequencer #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 9,
  parameter int SRAM_ADDR_W = 8,
  parameter int SRAM_RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  output logic                   fetch_req,
  input  logic                   instr_valid,
  input  logic [7:0]             instr_byte,
  input  logic [DATA_W-1:0]      operand1,
  input  logic [DATA_W-1:0]      operand2,
  input  logic [4*DATA_W-1:0]    regs_flat,
  input  logic                   zero_flag,
  input  logic [DATA_W-1:0]      res,
  output logic [2:0]             alu_inst,
  output logic [DATA_W-1:0]      op_1,
  output logic [DATA_W-1:0]      op_2,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_rd_en,
  output logic                   sram_wr_en,
  output logic [DATA_W-1:0]      sram_wr_data,
  input  logic [DATA_W-1:0]      sram_rd_data,
  output logic                   reg_wr_en,
  output logic [1:0]             reg_wr_addr,
  output logic [DATA_W-1:0]      reg_wr_data,
  output logic                   pc_adv,
  output logic [1:0]             instr_size,
  output logic                   jmp_en,
  output logic [PC_W-1:0]        jmp_addr,
  output logic                   halted,
  output logic                   illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR, S_ALU, S_EXEC, S_RETIRE, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          opc_q, opc_d;
  logic [1:0]          rd_q, rd_d, rs_q, rs_d;
  logic [DATA_W-1:0]   op1_q, op1_d, data_q, data_d;
  logic [PC_W-1:0]     tgt_q, tgt_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                illegal_q, illegal_d;
  logic                started_q;
  logic [DATA_W-1:0]   regs [4];
  logic [2*DATA_W-1:0] jmp_full;
  logic                unused_jmp_bits;

  for (genvar i = 0; i < 4; i++) begin : g_regs
    assign regs[i] = regs_flat[i*DATA_W +: DATA_W];
  end

  assign jmp_full        = {operand2, operand1};
  assign unused_jmp_bits = ^jmp_full;
  assign illegal         = illegal_q;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      op1_q     <= '0;
      data_q    <= '0;
      tgt_q     <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      op1_q     <= op1_d;
      data_q    <= data_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    op1_d        = op1_q;
    data_d       = data_q;
    tgt_d        = tgt_q;
    cnt_d        = cnt_q;
    illegal_d    = illegal_q;
    fetch_req    = 1'b0;
    alu_inst     = '0;
    op_1         = '0;
    op_2         = '0;
    sram_addr    = '0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_wr_data = '0;
    reg_wr_en    = 1'b0;
    reg_wr_addr  = '0;
    reg_wr_data  = '0;
    pc_adv       = 1'b0;
    instr_size   = '0;
    jmp_en       = 1'b0;
    jmp_addr     = '0;
    halted       = 1'b0;
    // Strobes are suppressed in the reset cycle so an aborted instruction never writes or retires.
    if (!sys_rst) begin
      case (state_q)
        S_FETCH: begin
          if (started_q) begin
            fetch_req = 1'b1;
            if (instr_valid) begin
              opc_d   = instr_byte[7:4];
              rd_d    = instr_byte[3:2];
              rs_d    = instr_byte[1:0];
              op1_d   = operand1;
              tgt_d   = jmp_full[PC_W-1:0];
              state_d = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          cnt_d = '0;
          if (opc_q[3]) illegal_d = 1'b1;
          case (opc_q)
            4'd2:    state_d = S_MEM_RD;
            4'd3:    state_d = S_MEM_WR;
            4'd4:    state_d = S_ALU;
            4'd7:    state_d = S_HALT;
            default: state_d = S_EXEC;
          endcase
        end
        S_MEM_RD: begin
          sram_addr  = op1_q[SRAM_ADDR_W-1:0];
          sram_rd_en = (cnt_q == 3'd0);
          if (cnt_q == 3'(SRAM_RD_LAT)) begin
            data_d  = sram_rd_data;
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_MEM_WR: begin
          sram_addr    = op1_q[SRAM_ADDR_W-1:0];
          sram_wr_data = regs[rs_q];
          sram_wr_en   = 1'b1;
          state_d      = S_RETIRE;
        end
        S_ALU: begin
          alu_inst = op1_q[2:0];
          op_1     = regs[rd_q];
          op_2     = regs[rs_q];
          data_d   = res;
          state_d  = S_EXEC;
        end
        S_EXEC: begin
          case (opc_q)
            4'd0:       begin reg_wr_en = 1'b1; reg_wr_addr = rd_q; reg_wr_data = regs[rs_q]; end
            4'd1:       begin reg_wr_en = 1'b1; reg_wr_addr = rd_q; reg_wr_data = op1_q;      end
            4'd2, 4'd4: begin reg_wr_en = 1'b1; reg_wr_addr = rd_q; reg_wr_data = data_q;     end
            default:    ;
          endcase
          state_d = S_RETIRE;
        end
        S_RETIRE: begin
          if (opc_q == 4'd5 || (opc_q == 4'd6 && zero_flag)) begin
            jmp_en   = 1'b1;
            jmp_addr = tgt_q;
          end else begin
            pc_adv = 1'b1;
            case (opc_q)
              4'd1, 4'd2, 4'd3, 4'd4: instr_size = 2'd2;
              4'd5, 4'd6:             instr_size = 2'd3;
              default:                instr_size = 2'd1;
            endcase
          end
          state_d = S_FETCH;
        end
        S_HALT: halted = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: expected strobe events (kind, addr, data, cycle after handshake) queued per instruction.
module tb_instr_sequencer;
  localparam int DW = 8, PW = 9, AW = 8, LAT = 3;

  logic clk = 1'b0, sys_rst = 1'b1;
  logic fetch_req, instr_valid = 1'b0, zero_flag = 1'b0;
  logic [7:0] instr_byte = '0;
  logic [DW-1:0] operand1 = '0, operand2 = '0, res, op_1, op_2, sram_wr_data, sram_rd_data, reg_wr_data;
  logic [4*DW-1:0] regs_flat;
  logic [2:0] alu_inst;
  logic [AW-1:0] sram_addr;
  logic sram_rd_en, sram_wr_en, reg_wr_en, pc_adv, jmp_en, halted, illegal;
  logic [1:0] reg_wr_addr, instr_size;
  logic [PW-1:0] jmp_addr;

  // kind: 1 reg write, 2 sram read, 3 sram write, 4 pc advance, 5 jump, 6 fetch_req rise
  typedef struct packed { int kind; int addr; int data; int cyc; } ev_t;
  ev_t exp_q[$], obs_q[$];
  int n_chk = 0, n_fail = 0, n_timeout = 0, n_multi = 0, n_fetch = 0, cyc = 0, hs = 0;
  logic [DW-1:0] rf [4];
  logic [DW-1:0] mem [256];
  logic [LAT-1:0] rd_vld = '0;
  logic [AW-1:0] rd_a [LAT];
  logic fr_prev = 1'b0;

  always #5 clk = ~clk;

  instr_sequencer #(.DATA_W(DW), .PC_W(PW), .SRAM_ADDR_W(AW), .SRAM_RD_LAT(LAT)) dut (
    .clk(clk), .sys_rst(sys_rst), .fetch_req(fetch_req), .instr_valid(instr_valid),
    .instr_byte(instr_byte), .operand1(operand1), .operand2(operand2), .regs_flat(regs_flat),
    .zero_flag(zero_flag), .res(res), .alu_inst(alu_inst), .op_1(op_1), .op_2(op_2),
    .sram_addr(sram_addr), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data), .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .pc_adv(pc_adv),
    .instr_size(instr_size), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .halted(halted),
    .illegal(illegal)
  );

  // Environment models: register file, ALU, SRAM with LAT-cycle read pipeline.
  assign regs_flat    = {rf[3], rf[2], rf[1], rf[0]};
  assign res          = (alu_inst == 3'd0) ? op_1 + op_2 : (alu_inst == 3'd1) ? op_1 - op_2 : op_1 ^ op_2;
  assign sram_rd_data = rd_vld[LAT-1] ? mem[rd_a[LAT-1]] : '0;

  always @(posedge clk) begin
    if (reg_wr_en) rf[reg_wr_addr] <= reg_wr_data;
    if (sram_wr_en) mem[sram_addr] <= sram_wr_data;
    rd_vld <= {rd_vld[LAT-2:0], sram_rd_en};
    rd_a[0] <= sram_addr;
    for (int i = 1; i < LAT; i++) rd_a[i] <= rd_a[i-1];
  end

  always @(negedge clk) begin
    #2;
    cyc++;
    if (fetch_req && instr_valid) hs = cyc;
    if ($countones({reg_wr_en, sram_rd_en, sram_wr_en}) > 1 || (pc_adv && jmp_en)) n_multi++;
    if (reg_wr_en)  obs_q.push_back('{1, int'(reg_wr_addr), int'(reg_wr_data), cyc - hs});
    if (sram_rd_en) obs_q.push_back('{2, int'(sram_addr), 0, cyc - hs});
    if (sram_wr_en) obs_q.push_back('{3, int'(sram_addr), int'(sram_wr_data), cyc - hs});
    if (pc_adv)     obs_q.push_back('{4, int'(instr_size), 0, cyc - hs});
    if (jmp_en)     obs_q.push_back('{5, int'(jmp_addr), 0, cyc - hs});
    if (fetch_req && !fr_prev) begin
      obs_q.push_back('{6, 0, 0, cyc - hs});
      n_fetch++;
    end
    fr_prev = fetch_req;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ib, input logic [7:0] o1, input logic [7:0] o2);
    int w = 0;
    while (!fetch_req && w < 40) begin tick(); w++; end
    if (!fetch_req) begin n_timeout++; $display("timeout waiting for fetch_req"); end
    instr_byte = ib; operand1 = o1; operand2 = o2; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic wait_fetch(input int snap);
    int w = 0;
    while (n_fetch == snap && w < 40) begin tick(); w++; end
    if (n_fetch == snap) begin n_timeout++; $display("timeout waiting for retire"); end
  endtask

  task automatic run(input logic [7:0] ib, input logic [7:0] o1, input logic [7:0] o2);
    int snap = n_fetch;
    issue(ib, o1, o2);
    wait_fetch(snap);
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({fetch_req, alu_inst, op_1, op_2, sram_addr, sram_rd_en, sram_wr_en, sram_wr_data,
                 reg_wr_en, reg_wr_addr, reg_wr_data, pc_adv, instr_size, jmp_en, jmp_addr, halted, illegal});
  endfunction

  task automatic test_reset();
    repeat (3) tick();
    sys_rst = 1'b0;
    n_chk++;
    if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_outs: got %0h, expected 0", all_outs()); end
    tick();
    n_chk++;
    if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL reset_fetch: fetch_req %b, expected 1", fetch_req); end
    tick();
  endtask

  task automatic test_mov_imm();
    ev_t e, o;
    obs_q.delete();
    exp_q.push_back('{1, 1, 'h5A, 2}); exp_q.push_back('{4, 2, 0, 3}); exp_q.push_back('{6, 0, 0, 4});
    run(8'h14, 8'h5A, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '{default: -1};
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL mov_imm: got k%0d a%0h d%0h c%0d, expected k%0d a%0h d%0h c%0d", o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc); end
    end
    n_chk++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL mov_imm_extra: %0d extra events, expected 0", obs_q.size()); end
  endtask

  task automatic test_mov_store();
    ev_t e, o;
    obs_q.delete();
    exp_q.push_back('{1, 0, 'h11, 2}); exp_q.push_back('{4, 2, 0, 3}); exp_q.push_back('{6, 0, 0, 4});
    exp_q.push_back('{3, 'h20, 'h11, 2}); exp_q.push_back('{4, 2, 0, 3}); exp_q.push_back('{6, 0, 0, 4});
    run(8'h10, 8'h11, 8'h00);
    run(8'h30, 8'h20, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '{default: -1};
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL mov_store: got k%0d a%0h d%0h c%0d, expected k%0d a%0h d%0h c%0d", o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc); end
    end
    n_chk++;
    if (mem[8'h20] !== 8'h11) begin n_fail++; $display("FAIL mov_store_mem: mem[20]=%0h, expected 11", mem[8'h20]); end
  endtask

  task automatic test_mov_load();
    ev_t e, o;
    obs_q.delete();
    exp_q.push_back('{1, 0, 'hC3, 2}); exp_q.push_back('{4, 2, 0, 3}); exp_q.push_back('{6, 0, 0, 4});
    exp_q.push_back('{3, 'h10, 'hC3, 2}); exp_q.push_back('{4, 2, 0, 3}); exp_q.push_back('{6, 0, 0, 4});
    exp_q.push_back('{2, 'h10, 0, 2}); exp_q.push_back('{1, 2, 'hC3, 6});
    exp_q.push_back('{4, 2, 0, 7}); exp_q.push_back('{6, 0, 0, 8});
    run(8'h10, 8'hC3, 8'h00);
    run(8'h30, 8'h10, 8'h00);
    run(8'h28, 8'h10, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '{default: -1};
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL mov_load: got k%0d a%0h d%0h c%0d, expected k%0d a%0h d%0h c%0d", o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc); end
    end
    n_chk++;
    if (rf[2] !== 8'hC3) begin n_fail++; $display("FAIL mov_load_reg: C=%0h, expected c3", rf[2]); end
  endtask

  task automatic test_alu();
    ev_t e, o;
    int snap;
    obs_q.delete();
    run(8'h10, 8'h03, 8'h00);
    run(8'h14, 8'h04, 8'h00);
    obs_q.delete();
    exp_q.push_back('{1, 0, 'h07, 3}); exp_q.push_back('{4, 2, 0, 4}); exp_q.push_back('{6, 0, 0, 5});
    exp_q.push_back('{1, 1, 'hFD, 3}); exp_q.push_back('{4, 2, 0, 4}); exp_q.push_back('{6, 0, 0, 5});
    snap = n_fetch;
    issue(8'h41, 8'h00, 8'h00);
    tick();
    n_chk++;
    if ({alu_inst, op_1, op_2} !== {3'd0, 8'd3, 8'd4}) begin n_fail++; $display("FAIL alu_operands: inst %0d op1 %0h op2 %0h, expected 0 3 4", alu_inst, op_1, op_2); end
    tick();
    n_chk++;
    if ({op_1, op_2} !== 16'h0) begin n_fail++; $display("FAIL alu_hold: op1 %0h op2 %0h after ALU cycle, expected 0 0", op_1, op_2); end
    wait_fetch(snap);
    run(8'h44, 8'h01, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '{default: -1};
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL alu: got k%0d a%0h d%0h c%0d, expected k%0d a%0h d%0h c%0d", o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc); end
    end
  endtask

  task automatic test_mov_reg();
    ev_t e, o;
    obs_q.delete();
    exp_q.push_back('{1, 3, 'h07, 2}); exp_q.push_back('{4, 1, 0, 3}); exp_q.push_back('{6, 0, 0, 4});
    run(8'h0C, 8'h00, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '{default: -1};
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL mov_reg: got k%0d a%0h d%0h c%0d, expected k%0d a%0h d%0h c%0d", o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc); end
    end
  endtask

  task automatic test_jump();
    ev_t e, o;
    obs_q.delete();
    exp_q.push_back('{5, 'h1F0, 0, 3}); exp_q.push_back('{6, 0, 0, 4});
    exp_q.push_back('{4, 3, 0, 3});     exp_q.push_back('{6, 0, 0, 4});
    exp_q.push_back('{5, 'h123, 0, 3}); exp_q.push_back('{6, 0, 0, 4});
    zero_flag = 1'b1;
    run(8'h60, 8'hF0, 8'h01);
    zero_flag = 1'b0;
    run(8'h60, 8'hF0, 8'h01);
    run(8'h50, 8'h23, 8'hFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '{default: -1};
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL jump: got k%0d a%0h d%0h c%0d, expected k%0d a%0h d%0h c%0d", o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc); end
    end
  endtask

  task automatic test_illegal();
    ev_t e, o;
    obs_q.delete();
    n_chk++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_pre: illegal %b, expected 0", illegal); end
    exp_q.push_back('{4, 1, 0, 3}); exp_q.push_back('{6, 0, 0, 4});
    run(8'hF0, 8'h00, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '{default: -1};
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL illegal_op: got k%0d a%0h d%0h c%0d, expected k%0d a%0h d%0h c%0d", o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc); end
    end
    n_chk++;
    if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: illegal %b, expected 1", illegal); end
  endtask

  task automatic test_reset_mid();
    ev_t e, o;
    obs_q.delete();
    exp_q.push_back('{2, 'h20, 0, 2}); exp_q.push_back('{6, 0, 0, 5});
    issue(8'h28, 8'h20, 8'h00);
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    n_chk++;
    if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_mid_outs: got %0h, expected 0", all_outs()); end
    tick();
    n_chk++;
    if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL reset_mid_fetch: fetch_req %b, expected 1", fetch_req); end
    repeat (6) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '{default: -1};
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL reset_mid: got k%0d a%0h d%0h c%0d, expected k%0d a%0h d%0h c%0d", o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc); end
    end
    n_chk++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_mid_extra: %0d extra events, expected 0", obs_q.size()); end
  endtask

  task automatic test_halt();
    int bad = 0;
    obs_q.delete();
    issue(8'h70, 8'h00, 8'h00);
    instr_byte = 8'h14; instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(halted === 1'b1 && fetch_req === 1'b0 && {reg_wr_en, sram_rd_en, sram_wr_en, pc_adv, jmp_en} === 5'b0)) bad++;
    end
    instr_valid = 1'b0;
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL halt_hold: %0d bad cycles, expected 0", bad); end
    n_chk++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL halt_events: %0d events, expected 0", obs_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mov_imm();
    test_mov_store();
    test_mov_load();
    test_alu();
    test_mov_reg();
    test_jump();
    test_illegal();
    test_reset_mid();
    test_halt();
    n_chk++;
    if (n_timeout != 0) begin n_fail++; $display("FAIL timeouts: %0d, expected 0", n_timeout); end
    n_chk++;
    if (n_multi != 0) begin n_fail++; $display("FAIL strobe_exclusive: %0d overlapping cycles, expected 0", n_multi); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Parametrised multi-cycle instruction sequencer for the CPU core. It replaces the fixed 8-bit decoder. It fetches an instruction word from PRAM over a request/valid handshake, then decodes it. It sequences register moves, SRAM load/store with configurable read latency, ALU operations, jumps and halt. It sits between PRAM/PC, register block, ALU and SRAM, and drives all their control strobes.

Parameters:
DATA_W, 8, datapath/register/SRAM data width
PC_W, 9, program counter / jump address width
SRAM_ADDR_W, 8, SRAM address width; taken from operand1[SRAM_ADDR_W-1:0]
SRAM_RD_LAT, 1, cycles from sram_rd_en to valid sram_rd_data (1..7)

Ports:
clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
fetch_req  out  1  request next instruction from PRAM
instr_valid  in  1  instr_byte/operand1/operand2 valid; sampled only while fetch_req=1
instr_byte  in  8  opcode [7:4], rd [3:2], rs [1:0]
operand1  in  DATA_W  immediate / SRAM address / ALU op / jump low
operand2  in  DATA_W  jump high
regs_flat  in  4*DATA_W  register file contents, reg n at [n*DATA_W +: DATA_W]
zero_flag  in  1  flags register zero bit
res  in  DATA_W  ALU result (combinational from op_1/op_2/alu_inst)
alu_inst  out  3  ALU operation
op_1, op_2  out  DATA_W  ALU operands
sram_addr  out  SRAM_ADDR_W  SRAM address
sram_rd_en  out  1  SRAM read strobe
sram_wr_en  out  1  SRAM write strobe
sram_wr_data  out  DATA_W  SRAM write data
sram_rd_data  in  DATA_W  SRAM read data
reg_wr_en  out  1  register write strobe
reg_wr_addr  out  2  destination register
reg_wr_data  out  DATA_W  register write data
pc_adv  out  1  one-cycle pulse: PC += instr_size
instr_size  out  2  bytes of retired instruction
jmp_en  out  1  one-cycle pulse: PC <= jmp_addr
jmp_addr  out  PC_W  jump target
halted  out  1  core halted
illegal  out  1  sticky: undefined opcode seen

Behaviour:
- Reset: all outputs 0, state FETCH; mid-instruction reset aborts with no further strobes and no retirement.
- Opcodes (size): 0 MOV rd,rs (1); 1 MOV rd,#op1 (2); 2 MOV rd,[op1] (2); 3 MOV [op1],rs (2); 4 ALU rd,rs with alu_inst=op1[2:0] (2); 5 JMP {op2,op1}[PC_W-1:0] (3); 6 JZ same target, taken iff zero_flag=1 (3); 7 HLT (1); 8-F: NOP, size 1, sets illegal.
- States:
  - FETCH: fetch_req=1 until instr_valid; latch instr/operands, go DECODE. fetch_req drops the cycle after the handshake.
  - DECODE: 2→MEM_RD; 3→MEM_WR; 4→ALU; 7→HALT; else EXEC.
  - MEM_RD: sram_addr=op1, sram_rd_en pulses 1 cycle; a counter waits SRAM_RD_LAT cycles; sram_rd_data is captured on the last cycle; go EXEC.
  - MEM_WR: sram_addr, sram_wr_data=reg[rs], sram_wr_en pulses 1 cycle; go RETIRE.
  - ALU: op_1=reg[rd], op_2=reg[rs], alu_inst held 1 cycle; res captured at cycle end; go EXEC.
  - EXEC: reg_wr_en pulse 1 cycle with addr/data for opcodes 0,1,2,4; go RETIRE.
  - RETIRE: exactly one of pc_adv (with instr_size) or jmp_en (with jmp_addr) pulses 1 cycle; JZ not taken uses pc_adv with size 3; go FETCH.
  - HALT: halted=1 permanently until sys_rst; no strobes; fetch_req=0.
- Cycle counts from handshake cycle to retire pulse:
  - MOV rd,rs / MOV rd,#: 3.
  - MOV rd,[a]: 4+SRAM_RD_LAT.
  - MOV [a],rs: 3.
  - ALU: 4.
  - JMP/JZ/NOP: 3.
- Strobe rules:
  - At most one of reg_wr_en/sram_rd_en/sram_wr_en high in any cycle.
  - reg_wr_data is stable while reg_wr_en=1.
  - Registers are read in the state that uses them; a write in EXEC is visible to the next instruction.
- Width rules: data paths are DATA_W; jump target is truncated to PC_W; upper operand1 bits beyond SRAM_ADDR_W are ignored.

Test Plan:
- MOV B,#0x5A (instr 0x14, op1 0x5A) → reg_wr_en 1 cycle, addr 1, data 0x5A; then pc_adv with instr_size=2; fetch_req reasserts the next cycle.
- SRAM_RD_LAT=3, mem[0x10]=0xC3, MOV C,[0x10] → sram_rd_en one cycle, addr 0x10; reg C written 0xC3 exactly 3 cycles later plus EXEC; retire at cycle 7.
- MOV [0x20],A with A=0x11 → sram_wr_en 1 cycle, addr 0x20, data 0x11; no reg_wr_en; pc_adv size 2.
- ALU add (op1=0) A,B with A=3, B=4, res=7 → op_1=3, op_2=4 for 1 cycle; A written 7; pc_adv size 2.
- JZ 0x1F0 (op2=0x01, op1=0xF0): zero_flag=1 → jmp_en, jmp_addr=0x1F0; zero_flag=0 → pc_adv size 3.
- HLT then instr_valid held high → halted=1, fetch_req=0 forever; opcode 0xF → illegal=1, pc_adv size 1; sys_rst asserted during MEM_RD wait → no reg_wr_en, all outputs 0 next cycle.
